// File: rtl/palindrome_pkg.sv
// Shared definitions for the palindrome line framer: newline code, framer states,
// default buffer depth and the character classification helpers.
package palindrome_pkg;

  localparam logic [7:0] NEWLINE       = 8'h0A;
  localparam int         DEPTH_DEFAULT = 64;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SEND = 2'd1,
    TERM = 2'd2,
    WAIT = 2'd3
  } framer_state_e;

  function automatic logic is_alnum(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) ||
           ((c >= 8'h41) && (c <= 8'h5A)) ||
           ((c >= 8'h30) && (c <= 8'h39));
  endfunction

  function automatic logic [7:0] fold_lower(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ? c + 8'h20 : c;
  endfunction

endpackage

// File: rtl/palindrome_line_buf.sv
// Line store for the framer: DEPTH x 8 bits, one synchronous write port and an
// asynchronous read port. Contents are never reset.
module palindrome_line_buf
  import palindrome_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/palindrome_line_framer.sv
// Collects one filtered, lower-cased line of ASCII input and replays it as a
// character burst to a palindrome checker, then waits for the checker's verdict.
module palindrome_line_framer
  import palindrome_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rawIn,
  input  logic             rawVld,
  output logic             rawReady,
  output logic [7:0]       charOut,
  output logic             charVld,
  input  logic             charReady,
  input  logic             resultVld,
  output logic             lineOvfl,
  output logic [CNT_W-1:0] lineCnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH) + 1;

  framer_state_e state, state_nxt;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    rd_data;
  logic          accept, keep, buf_full, wr_en, last_char;

  assign accept    = rawVld && (state == FILL);
  assign keep      = accept && is_alnum(rawIn);
  assign buf_full  = (wr_ptr == PW'(DEPTH));
  assign wr_en     = keep && !buf_full;
  assign last_char = (rd_ptr == wr_ptr - PW'(1));

  palindrome_line_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (fold_lower(rawIn)),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && (rawIn == NEWLINE) && (wr_ptr != '0)) state_nxt = SEND;
      SEND:    if (charReady && last_char) state_nxt = TERM;
      TERM:    state_nxt = WAIT;
      WAIT:    if (resultVld) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Pointer, overflow and line-count bookkeeping follows the current state.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lineOvfl <= 1'b0;
      lineCnt  <= '0;
    end else begin
      case (state)
        FILL: begin
          if (wr_en) wr_ptr <= wr_ptr + PW'(1);
          if (keep && buf_full) lineOvfl <= 1'b1;
          if (state_nxt == SEND) rd_ptr <= '0;
        end
        SEND: begin
          if (charReady) rd_ptr <= rd_ptr + PW'(1);
        end
        WAIT: begin
          if (resultVld) begin
            lineCnt  <= lineCnt + CNT_W'(1);
            wr_ptr   <= '0;
            lineOvfl <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rawReady = (state == FILL);
  assign charVld  = (state == SEND);
  assign charOut  = charVld ? rd_data : 8'h00;

endmodule
